captura_jogada: RTL and testbench
=================================

Name: captura_jogada

Overview:
- Input stage that sits directly upstream of circuito_CL. It turns the raw board inputs into the jogadaFileira, jogadaColuna and temJogada signals that circuito_CL consumes.
- Raw inputs are 4 row switches, 4 column switches and a confirm button.
- All 9 raw inputs are synchronized and debounced.
- On a confirm press, the block checks that exactly one row and exactly one column are selected.
- A valid move produces a single-cycle temJogada pulse with the row/column values held stable. An invalid move produces a single-cycle jogada_invalida pulse.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a new input value (1 ms at 50 MHz; the bench uses 8).
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- fileiras  in  4  raw row switches, active-high, asynchronous to clock
- colunas  in  4  raw column switches, active-high, asynchronous to clock
- confirmar  in  1  raw confirm button, active-high, asynchronous to clock
- habilitar  in  1  from the game FSM; 1 = a move is awaited
- jogadaFileira  out  4  latched one-hot row of the last valid move
- jogadaColuna  out  4  latched one-hot column of the last valid move
- temJogada  out  1  one-cycle pulse: a valid move is presented
- jogada_invalida  out  1  one-cycle pulse: confirm pressed with a selection that is not one-hot
- db_estado  out  3  current FSM state code, for debug

Behaviour:
- Clock and reset: one clock domain (clock). Reset is asynchronous and active-high.
- Reset values: all outputs 0, db_estado=0, synchronizer and stable registers 0, counter 0.
- Synchronizer: 2-flop synchronizer on all 9 raw bits, forming vector s[8:0] = {confirmar, fileiras, colunas}.
- Debounce:
  - Counter clears whenever s differs from the previous s.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES.
  - The stable vector d is loaded with s on the edge where the counter reaches DEBOUNCE_CYCLES-1.
  - Glitches shorter than DEBOUNCE_CYCLES never reach d.
- Edge detect: conf_rise = d.confirmar & ~d_prev.confirmar.
- FSM states (codes in parentheses):
  - ESPERA_HAB (0): waits for habilitar=1, then goes to ESPERA_CONF.
  - ESPERA_CONF (1):
    - habilitar=0: return to ESPERA_HAB. This has priority over conf_rise in the same cycle.
    - conf_rise: latch d.fileiras and d.colunas into capture registers, go to VALIDA.
  - VALIDA (2): if both captured fields are one-hot (exactly one bit set), go to EMITE; otherwise go to INVALIDA.
  - EMITE (3):
    - temJogada=1 for this cycle only.
    - jogadaFileira and jogadaColuna are updated from the capture registers on entry, so they are valid in the same cycle as temJogada.
    - Next state: ESPERA_SOLTAR.
  - INVALIDA (4): jogada_invalida=1 for this cycle only; jogadaFileira/jogadaColuna unchanged. Next state: ESPERA_SOLTAR.
  - ESPERA_SOLTAR (5): waits for d.confirmar=0. Then goes to ESPERA_CONF if habilitar=1, else ESPERA_HAB. This prevents a held button from producing repeat moves.
- Output hold: jogadaFileira and jogadaColuna hold their value until the next EMITE. circuito_CL may sample them at any time.
- Latency: the first clock edge that samples a new raw confirmar value is edge 0. temJogada is high in the cycle after edge DEBOUNCE_CYCLES+5, which is exact and checked by the bench.
- Selection changing after confirm: row or column switch changes after conf_rise do not affect the captured move.
- habilitar dropping in VALIDA, EMITE or INVALIDA: the sequence completes; the pulse is still issued.
- Reset mid-operation: the FSM returns immediately to ESPERA_HAB, no pulse is emitted, and all registers clear.
- temJogada and jogada_invalida are never high in the same cycle.
- Unused codes 6 and 7: next state is ESPERA_HAB.

Decomposition:
- Package captura_pkg:
  - state encoding constants ESPERA_HAB..ESPERA_SOLTAR (3-bit)
  - default DEBOUNCE_CYCLES
  - function eh_one_hot(4-bit) returning 1 when exactly one bit is set
- Sub-module debounce (parameters WIDTH, DEBOUNCE_CYCLES, CNT_W): contains the synchronizer, counter and stable register. Instantiated once with WIDTH=9.
- The FSM and capture registers live in captura_jogada.

Test Plan:
- Reset and idle: pulse reset for 1 cycle with DEBOUNCE_CYCLES=8 -> all outputs 0, db_estado=0; stays 0 while habilitar=0, even with confirmar toggling.
- Valid move:
  - Stimulus: habilitar=1, fileiras=4'b0010, colunas=4'b0010, then confirmar=1 after 20 cycles.
  - Expected: temJogada high for exactly 1 cycle, 13 cycles after confirm is first sampled; jogadaFileira=4'b0010, jogadaColuna=4'b0010 in that cycle, held afterwards.
- Invalid move: fileiras=4'b0110, colunas=4'b0001, confirm pressed -> jogada_invalida 1 cycle; temJogada stays 0; outputs keep the previous 4'b0010/4'b0010.
- Glitch and held button:
  - A 5-cycle confirm glitch -> no pulse.
  - Confirm held for 200 cycles -> exactly one temJogada.
  - Release then press again -> a second temJogada.
- Disable race: habilitar falls in the same cycle as conf_rise -> no pulse, db_estado=0.
- Reset mid-operation: reset asserted while db_estado=2 -> all outputs 0 within the reset cycle; after release, a new valid move is captured normally.

Source files
------------

// File: rtl/captura_jogada_pkg.sv
// Shared definitions for the captura_jogada move-capture stage: state codes,
// default debounce length and the one-hot test used by the validation state.
package captura_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 50000;

    typedef enum logic [2:0] {
        ESPERA_HAB    = 3'd0,
        ESPERA_CONF   = 3'd1,
        VALIDA        = 3'd2,
        EMITE         = 3'd3,
        INVALIDA      = 3'd4,
        ESPERA_SOLTAR = 3'd5
    } estado_t;

    // A nonzero value with its lowest set bit cleared is zero only when one bit was set.
    function automatic logic eh_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/captura_jogada_if.sv
// Board-side and game-side signals of captura_jogada, grouped as one bundle.
interface captura_jogada_if;

    logic [3:0] fileiras;
    logic [3:0] colunas;
    logic       confirmar;
    logic       habilitar;
    logic [3:0] jogadaFileira;
    logic [3:0] jogadaColuna;
    logic       temJogada;
    logic       jogada_invalida;
    logic [2:0] db_estado;

    modport master (
        output fileiras, colunas, confirmar, habilitar,
        input  jogadaFileira, jogadaColuna, temJogada, jogada_invalida, db_estado
    );

    modport slave (
        input  fileiras, colunas, confirmar, habilitar,
        output jogadaFileira, jogadaColuna, temJogada, jogada_invalida, db_estado
    );

endinterface

// File: rtl/captura_jogada_debounce.sv
// Two-flop synchronizer plus whole-vector debounce: any bit change restarts the
// stability count, and the stable copy is refreshed once the count runs out.
module debounce #(
    parameter int WIDTH           = 9,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_stable
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_sync2 != r_prev) begin
                r_cnt <= '0;
            end else begin
                if (r_cnt != CNT_MAX)
                    r_cnt <= r_cnt + CNT_ONE;
                // Counter saturates past CNT_LOAD, so the load happens once per stable period.
                if (r_cnt == CNT_LOAD)
                    r_stable <= r_sync2;
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/captura_jogada.sv
// Move capture: debounced switches/button feed an FSM that validates the
// selection on a confirm press and emits a one-cycle valid or invalid pulse.
//
//   state         | meaning
//   ESPERA_HAB    | idle, game FSM not asking for a move
//   ESPERA_CONF   | waiting for a confirm rising edge
//   VALIDA        | checking captured row/column are one-hot
//   EMITE         | temJogada pulse, move outputs updated
//   INVALIDA      | jogada_invalida pulse
//   ESPERA_SOLTAR | waiting for the button release
module captura_jogada
    import captura_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 16
) (
    input logic             clock,
    input logic             reset,
    captura_jogada_if.slave bus
);

    logic [8:0] w_raw;
    logic [8:0] w_d;
    logic       w_d_conf;
    logic [3:0] w_d_fil;
    logic [3:0] w_d_col;

    logic       r_d_conf_prev;
    logic       r_conf_rise;
    estado_t    r_estado;
    logic [3:0] r_cap_fil;
    logic [3:0] r_cap_col;
    logic [3:0] r_jog_fil;
    logic [3:0] r_jog_col;
    logic       r_tem;
    logic       r_inv;

    assign w_raw = {bus.confirmar, bus.fileiras, bus.colunas};

    debounce #(
        .WIDTH          (9),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .clock   (clock),
        .reset   (reset),
        .i_raw   (w_raw),
        .o_stable(w_d)
    );

    assign w_d_conf = w_d[8];
    assign w_d_fil  = w_d[7:4];
    assign w_d_col  = w_d[3:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_d_conf_prev <= 1'b0;
            r_conf_rise   <= 1'b0;
        end else begin
            r_d_conf_prev <= w_d_conf;
            r_conf_rise   <= w_d_conf & ~r_d_conf_prev;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado  <= ESPERA_HAB;
            r_cap_fil <= 4'd0;
            r_cap_col <= 4'd0;
            r_jog_fil <= 4'd0;
            r_jog_col <= 4'd0;
            r_tem     <= 1'b0;
            r_inv     <= 1'b0;
        end else begin
            r_tem <= 1'b0;
            r_inv <= 1'b0;
            case (r_estado)
                ESPERA_HAB: begin
                    if (bus.habilitar)
                        r_estado <= ESPERA_CONF;
                end
                ESPERA_CONF: begin
                    // Losing habilitar wins over a confirm edge in the same cycle.
                    if (!bus.habilitar) begin
                        r_estado <= ESPERA_HAB;
                    end else if (r_conf_rise) begin
                        r_cap_fil <= w_d_fil;
                        r_cap_col <= w_d_col;
                        r_estado  <= VALIDA;
                    end
                end
                VALIDA: begin
                    if (eh_one_hot(r_cap_fil) && eh_one_hot(r_cap_col)) begin
                        r_jog_fil <= r_cap_fil;
                        r_jog_col <= r_cap_col;
                        r_tem     <= 1'b1;
                        r_estado  <= EMITE;
                    end else begin
                        r_inv    <= 1'b1;
                        r_estado <= INVALIDA;
                    end
                end
                EMITE:    r_estado <= ESPERA_SOLTAR;
                INVALIDA: r_estado <= ESPERA_SOLTAR;
                ESPERA_SOLTAR: begin
                    if (!w_d_conf)
                        r_estado <= bus.habilitar ? ESPERA_CONF : ESPERA_HAB;
                end
                default: r_estado <= ESPERA_HAB;
            endcase
        end
    end

    assign bus.jogadaFileira   = r_jog_fil;
    assign bus.jogadaColuna    = r_jog_col;
    assign bus.temJogada       = r_tem;
    assign bus.jogada_invalida = r_inv;
    assign bus.db_estado       = r_estado;

endmodule

// File: tb/tb_captura_jogada.sv
// Table of confirm presses checked through a pulse scoreboard, plus hand-written
// glitch, disable-race and reset-during-validation sequences.
module tb_captura_jogada;

    localparam int DC = 8;

    typedef struct {
        logic       inv;
        logic [3:0] f;
        logic [3:0] c;
    } exp_t;

    typedef struct {
        logic [3:0] f;
        logic [3:0] c;
        logic       inv;
        logic [3:0] ef;
        logic [3:0] ec;
        int         hold;
        logic       chg;
        int         drop_k;
    } vec_t;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   n_pulses;
    exp_t sb[$];
    vec_t vecs[9];

    captura_jogada_if u_if ();

    captura_jogada #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (u_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Scoreboard: every pulse must match the oldest pending expectation.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && (u_if.temJogada || u_if.jogada_invalida)) begin
            n_pulses++;
            if (sb.size() == 0) begin
                check("unexpected_pulse", {u_if.temJogada, u_if.jogada_invalida}, 0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", {u_if.temJogada, u_if.jogada_invalida}, e.inv ? 2'b01 : 2'b10);
                check("pulse_fil", u_if.jogadaFileira, e.f);
                check("pulse_col", u_if.jogadaColuna, e.c);
            end
        end
    end

    task automatic press(input vec_t v);
        int   lat;
        exp_t e;
        u_if.fileiras = v.f;
        u_if.colunas  = v.c;
        repeat (20) @(negedge clock);
        e.inv = v.inv;
        e.f   = v.ef;
        e.c   = v.ec;
        sb.push_back(e);
        u_if.confirmar = 1'b1;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (v.chg && k == 10) begin
                u_if.fileiras = ~v.f;
                u_if.colunas  = ~v.c;
            end
            if (k == v.drop_k) begin
                check("estado_valida", u_if.db_estado, 2);
                u_if.habilitar = 1'b0;
            end
            if (u_if.temJogada || u_if.jogada_invalida) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, DC + 5);
        repeat (v.hold) @(negedge clock);
        u_if.confirmar = 1'b0;
        repeat (20) @(negedge clock);
        check("estado_pos", u_if.db_estado, u_if.habilitar ? 1 : 0);
        check("hold_fil", u_if.jogadaFileira, v.ef);
        check("hold_col", u_if.jogadaColuna, v.ec);
        u_if.habilitar = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses_before;
        int waited;
        vec_t v;

        n_tests  = 0;
        n_fail   = 0;
        n_pulses = 0;

        //            f        c        inv   ef       ec       hold chg   drop
        vecs[0] = '{4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0010, 5,   1'b0, -1};
        vecs[1] = '{4'b0110, 4'b0001, 1'b1, 4'b0010, 4'b0010, 5,   1'b0, -1};
        vecs[2] = '{4'b1000, 4'b0100, 1'b0, 4'b1000, 4'b0100, 200, 1'b0, -1};
        vecs[3] = '{4'b0001, 4'b1000, 1'b0, 4'b0001, 4'b1000, 5,   1'b0, -1};
        vecs[4] = '{4'b0000, 4'b0001, 1'b1, 4'b0001, 4'b1000, 5,   1'b0, -1};
        vecs[5] = '{4'b0100, 4'b1100, 1'b1, 4'b0001, 4'b1000, 5,   1'b0, -1};
        vecs[6] = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0001, 5,   1'b1, -1};
        vecs[7] = '{4'b0100, 4'b0010, 1'b0, 4'b0100, 4'b0010, 5,   1'b0, 12};
        vecs[8] = '{4'b0010, 4'b1000, 1'b0, 4'b0010, 4'b1000, 5,   1'b0, -1};

        reset          = 1'b1;
        u_if.fileiras  = 4'd0;
        u_if.colunas   = 4'd0;
        u_if.confirmar = 1'b0;
        u_if.habilitar = 1'b0;
        @(negedge clock);
        check("reset_state", {u_if.jogadaFileira, u_if.jogadaColuna, u_if.temJogada,
                              u_if.jogada_invalida, u_if.db_estado}, 0);
        reset = 1'b0;

        // Idle: confirm toggling while not enabled must not move the FSM.
        for (int i = 0; i < 3; i++) begin
            u_if.confirmar = 1'b1;
            repeat (20) @(negedge clock);
            check("idle_estado_hi", u_if.db_estado, 0);
            u_if.confirmar = 1'b0;
            repeat (20) @(negedge clock);
            check("idle_estado_lo", u_if.db_estado, 0);
        end
        check("idle_pulses", n_pulses, 0);

        u_if.habilitar = 1'b1;
        repeat (2) @(negedge clock);
        check("enable_estado", u_if.db_estado, 1);

        for (int i = 0; i < 8; i++) press(vecs[i]);

        // Confirm glitch shorter than the debounce window.
        pulses_before = n_pulses;
        u_if.confirmar = 1'b1;
        repeat (5) @(negedge clock);
        u_if.confirmar = 1'b0;
        repeat (30) @(negedge clock);
        check("glitch_pulses", n_pulses, pulses_before);
        check("glitch_estado", u_if.db_estado, 1);

        // habilitar falls in the very cycle the confirm edge is presented.
        u_if.fileiras = 4'b0010;
        u_if.colunas  = 4'b0100;
        repeat (20) @(negedge clock);
        u_if.confirmar = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k == 11) u_if.habilitar = 1'b0;
        end
        repeat (20) @(negedge clock);
        check("race_estado", u_if.db_estado, 0);
        check("race_pulses", n_pulses, pulses_before);
        u_if.confirmar = 1'b0;
        repeat (20) @(negedge clock);
        u_if.habilitar = 1'b1;
        repeat (2) @(negedge clock);

        // Reset while validating: no pulse, everything cleared, then a normal move.
        u_if.fileiras = 4'b1000;
        u_if.colunas  = 4'b0001;
        repeat (20) @(negedge clock);
        u_if.confirmar = 1'b1;
        waited = 0;
        while (u_if.db_estado != 3'd2 && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        check("reach_valida", u_if.db_estado, 2);
        reset = 1'b1;
        #1;
        check("midreset_out", {u_if.jogadaFileira, u_if.jogadaColuna, u_if.temJogada,
                               u_if.jogada_invalida, u_if.db_estado}, 0);
        u_if.confirmar = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        check("midreset_pulses", n_pulses, pulses_before);
        check("midreset_estado", u_if.db_estado, 1);
        v = vecs[8];
        press(v);

        repeat (10) @(negedge clock);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
